// File: rtl/hazard_forward_ctrl.sv
// Data-hazard control for the 5-stage core: three-level operand forwarding,
// load-use bubble insertion, and a data-memory wait freeze with a watchdog.
module hazard_forward_ctrl #(
    parameter int REG_AW           = 5,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int HIST_EN          = 1,
    parameter int MEM_TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_ex_rs1,
    input  logic [REG_AW-1:0] id_ex_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_memread,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_regwrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_regwrite,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic [1:0]        fwd_rs1,
    output logic [1:0]        fwd_rs2,
    output logic              hist_we,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_flush,
    output logic              pipe_freeze,
    output logic              mem_timeout
);

    typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

    localparam logic [2:0]  BUB_INIT  = (LOAD_USE_BUBBLES > 1) ? 3'(LOAD_USE_BUBBLES - 2) : 3'd0;
    localparam logic [15:0] WAIT_MAX  = 16'(MEM_TIMEOUT);
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic        HIST_ON   = (HIST_EN != 0);

    state_t            state, state_nxt;
    logic [2:0]        bub_cnt, bub_cnt_nxt;
    logic [15:0]       wait_cnt;
    logic              timeout_q;
    logic              hist_valid;
    logic [REG_AW-1:0] hist_rd;
    logic              frozen;
    logic              lu;
    logic              retire_we;

    function automatic logic [1:0] fwd_select(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == src)
            sel = 2'b01;
        else if (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == src)
            sel = 2'b10;
        else if (HIST_ON && hist_valid && hist_rd == src)
            sel = 2'b11;
        return sel;
    endfunction

    assign frozen    = dmem_req && !dmem_ready;
    assign retire_we = mem_wb_regwrite && mem_wb_rd != '0 && !frozen && !rst;
    assign lu        = id_ex_memread && id_ex_rd != '0 &&
                       ((id_uses_rs1 && id_rs1 == id_ex_rd) ||
                        (id_uses_rs2 && id_rs2 == id_ex_rd));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            bub_cnt <= 3'd0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_cnt_nxt;
        end
    end

    // A freeze parks the bubble sequence so the total bubble count stays exact.
    always_comb begin
        state_nxt   = state;
        bub_cnt_nxt = bub_cnt;
        if (!frozen) begin
            case (state)
                RUN: begin
                    if (lu && LOAD_USE_BUBBLES > 1) begin
                        state_nxt   = BUBBLE;
                        bub_cnt_nxt = BUB_INIT;
                    end
                end
                BUBBLE: begin
                    if (bub_cnt == 3'd0)
                        state_nxt = RUN;
                    else
                        bub_cnt_nxt = bub_cnt - 3'd1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        fwd_rs1     = 2'b00;
        fwd_rs2     = 2'b00;
        hist_we     = 1'b0;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        mem_timeout = 1'b0;
        if (!rst) begin
            fwd_rs1     = fwd_select(id_ex_rs1);
            fwd_rs2     = fwd_select(id_ex_rs2);
            hist_we     = retire_we;
            pipe_freeze = frozen;
            mem_timeout = timeout_q;
            if (frozen) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
            end else if (state == BUBBLE || lu) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Watchdog counts consecutive frozen cycles; the timeout flag is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else if (frozen) begin
            if (wait_cnt == WAIT_LAST)
                timeout_q <= 1'b1;
            if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_valid <= 1'b0;
            hist_rd    <= '0;
        end else if (retire_we) begin
            hist_valid <= 1'b1;
            hist_rd    <= mem_wb_rd;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: two differently parameterised instances share
// stimulus and are compared every cycle against a bubble-debt reference model.
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic       id_uses_rs1, id_uses_rs2, id_ex_memread, ex_mem_regwrite, mem_wb_regwrite;
    logic       dmem_req, dmem_ready;

    logic [1:0] a_fwd_rs1, a_fwd_rs2, b_fwd_rs1, b_fwd_rs2;
    logic       a_hist_we, a_pc_stall, a_if_id_stall, a_id_ex_flush, a_pipe_freeze, a_mem_timeout;
    logic       b_hist_we, b_pc_stall, b_if_id_stall, b_id_ex_flush, b_pipe_freeze, b_mem_timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.REG_AW(5), .LOAD_USE_BUBBLES(3), .HIST_EN(1), .MEM_TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fwd_rs1(a_fwd_rs1), .fwd_rs2(a_fwd_rs2), .hist_we(a_hist_we),
        .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall), .id_ex_flush(a_id_ex_flush),
        .pipe_freeze(a_pipe_freeze), .mem_timeout(a_mem_timeout));

    hazard_forward_ctrl #(.REG_AW(5), .LOAD_USE_BUBBLES(1), .HIST_EN(0), .MEM_TIMEOUT(6)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .fwd_rs1(b_fwd_rs1), .fwd_rs2(b_fwd_rs2), .hist_we(b_hist_we),
        .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .id_ex_flush(b_id_ex_flush),
        .pipe_freeze(b_pipe_freeze), .mem_timeout(b_mem_timeout));

    // Reference model: tracks bubbles still owed rather than an FSM state.
    typedef struct {
        int         owed;
        int         frozen_run;
        bit         tmo;
        bit         hv;
        logic [4:0] hrd;
    } mstate_t;

    typedef struct packed {
        logic [1:0] f1;
        logic [1:0] f2;
        logic       hwe;
        logic       pcs;
        logic       ifs;
        logic       fl;
        logic       frz;
        logic       tmo;
    } mout_t;

    typedef struct {
        logic [4:0] em_rd;
        logic       em_we;
        logic [4:0] mw_rd;
        logic       mw_we;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] a1;
        logic [1:0] a2;
        logic       hwe;
        logic [1:0] b1;
        logic [1:0] b2;
    } vec_t;

    mstate_t ma, mb;

    function automatic logic ref_freeze();
        return dmem_req && !dmem_ready;
    endfunction

    function automatic logic ref_lu();
        return id_ex_memread && id_ex_rd != 0 &&
               ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
    endfunction

    function automatic logic [1:0] ref_fwd(logic [4:0] src, mstate_t s, int hist_en);
        if (src == 0) return 2'd0;
        if (ex_mem_regwrite && ex_mem_rd == src) return 2'd1;
        if (mem_wb_regwrite && mem_wb_rd == src) return 2'd2;
        if (hist_en != 0 && s.hv && s.hrd == src) return 2'd3;
        return 2'd0;
    endfunction

    function automatic mout_t ref_out(mstate_t s, int hist_en);
        mout_t o;
        o = '0;
        if (rst) return o;
        o.f1  = ref_fwd(id_ex_rs1, s, hist_en);
        o.f2  = ref_fwd(id_ex_rs2, s, hist_en);
        o.hwe = mem_wb_regwrite && mem_wb_rd != 0 && !ref_freeze();
        o.frz = ref_freeze();
        o.tmo = s.tmo;
        if (ref_freeze()) begin
            o.pcs = 1'b1;
            o.ifs = 1'b1;
        end else if (s.owed > 0 || ref_lu()) begin
            o.pcs = 1'b1;
            o.ifs = 1'b1;
            o.fl  = 1'b1;
        end
        return o;
    endfunction

    function automatic mstate_t ref_step(mstate_t s, int lub, int mt);
        mstate_t n;
        n = s;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        if (mem_wb_regwrite && mem_wb_rd != 0 && !ref_freeze()) begin
            n.hv  = 1'b1;
            n.hrd = mem_wb_rd;
        end
        if (ref_freeze()) begin
            n.frozen_run = s.frozen_run + 1;
            if (n.frozen_run >= mt) n.tmo = 1'b1;
        end else begin
            n.frozen_run = 0;
            if (s.owed > 0) n.owed = s.owed - 1;
            else if (ref_lu()) n.owed = lub - 1;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareModel(input string tag, input mout_t act, input mout_t exp);
        checkOutput({tag, ".fwd_rs1"},     16'(act.f1),  16'(exp.f1));
        checkOutput({tag, ".fwd_rs2"},     16'(act.f2),  16'(exp.f2));
        checkOutput({tag, ".hist_we"},     16'(act.hwe), 16'(exp.hwe));
        checkOutput({tag, ".pc_stall"},    16'(act.pcs), 16'(exp.pcs));
        checkOutput({tag, ".if_id_stall"}, 16'(act.ifs), 16'(exp.ifs));
        checkOutput({tag, ".id_ex_flush"}, 16'(act.fl),  16'(exp.fl));
        checkOutput({tag, ".pipe_freeze"}, 16'(act.frz), 16'(exp.frz));
        checkOutput({tag, ".mem_timeout"}, 16'(act.tmo), 16'(exp.tmo));
    endtask

    // Sample at the falling edge, away from the state-updating rising edge.
    task automatic applyStimulus();
        mout_t act_a, act_b;
        @(negedge clk);
        act_a = '{a_fwd_rs1, a_fwd_rs2, a_hist_we, a_pc_stall, a_if_id_stall,
                  a_id_ex_flush, a_pipe_freeze, a_mem_timeout};
        act_b = '{b_fwd_rs1, b_fwd_rs2, b_hist_we, b_pc_stall, b_if_id_stall,
                  b_id_ex_flush, b_pipe_freeze, b_mem_timeout};
        compareModel("a", act_a, ref_out(ma, 1));
        compareModel("b", act_b, ref_out(mb, 0));
    endtask

    task automatic endCycle();
        @(posedge clk);
        ma = ref_step(ma, 3, 4);
        mb = ref_step(mb, 1, 6);
        #1;
    endtask

    task automatic clearInputs();
        rst = 1'b0;
        {id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd} = '0;
        {id_uses_rs1, id_uses_rs2, id_ex_memread, ex_mem_regwrite, mem_wb_regwrite} = '0;
        dmem_req   = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic setLoadUse();
        id_ex_memread = 1'b1;
        id_ex_rd      = 5'd3;
        id_rs2        = 5'd3;
        id_uses_rs2   = 1'b1;
    endtask

    task automatic pulseReset();
        clearInputs();
        rst = 1'b1;
        applyStimulus();
        endCycle();
        rst = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        int   flushes;

        ma = '{default: 0};
        mb = '{default: 0};

        vecs[0] = '{5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd9, 2'd1, 2'd0, 1'b1, 2'd1, 2'd0};
        vecs[1] = '{5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd9, 2'd1, 2'd0, 1'b1, 2'd1, 2'd0};
        vecs[2] = '{5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 5'd9, 2'd2, 2'd0, 1'b1, 2'd2, 2'd0};
        vecs[3] = '{5'd5, 1'b0, 5'd5, 1'b0, 5'd5, 5'd9, 2'd3, 2'd0, 1'b0, 2'd0, 2'd0};
        vecs[4] = '{5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd9, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0};
        vecs[5] = '{5'd5, 1'b0, 5'd7, 1'b1, 5'd0, 5'd7, 2'd0, 2'd2, 1'b1, 2'd0, 2'd2};
        vecs[6] = '{5'd5, 1'b0, 5'd7, 1'b0, 5'd0, 5'd7, 2'd0, 2'd3, 1'b0, 2'd0, 2'd0};

        // Reset with busy inputs: every output must still read zero.
        clearInputs();
        rst = 1'b1;
        dmem_req = 1'b1;
        ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd5; id_ex_rs1 = 5'd5;
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd5;
        setLoadUse();
        applyStimulus();
        checkOutput("reset.fwd_rs1", 16'(a_fwd_rs1), 16'd0);
        checkOutput("reset.pipe_freeze", 16'(a_pipe_freeze), 16'd0);
        checkOutput("reset.hist_we", 16'(a_hist_we), 16'd0);
        checkOutput("reset.id_ex_flush", 16'(a_id_ex_flush), 16'd0);
        endCycle();

        for (int i = 0; i < 7; i++) begin
            clearInputs();
            ex_mem_rd = vecs[i].em_rd; ex_mem_regwrite = vecs[i].em_we;
            mem_wb_rd = vecs[i].mw_rd; mem_wb_regwrite = vecs[i].mw_we;
            id_ex_rs1 = vecs[i].rs1;   id_ex_rs2 = vecs[i].rs2;
            applyStimulus();
            checkOutput($sformatf("vec%0d.a_rs1", i), 16'(a_fwd_rs1), 16'(vecs[i].a1));
            checkOutput($sformatf("vec%0d.a_rs2", i), 16'(a_fwd_rs2), 16'(vecs[i].a2));
            checkOutput($sformatf("vec%0d.hist_we", i), 16'(a_hist_we), 16'(vecs[i].hwe));
            checkOutput($sformatf("vec%0d.b_rs1", i), 16'(b_fwd_rs1), 16'(vecs[i].b1));
            checkOutput($sformatf("vec%0d.b_rs2", i), 16'(b_fwd_rs2), 16'(vecs[i].b2));
            endCycle();
        end

        // Single load-use hazard: 3 bubbles on instance a, 1 on instance b.
        clearInputs();
        setLoadUse();
        applyStimulus();
        checkOutput("lu.first_a_flush", 16'(a_id_ex_flush), 16'd1);
        checkOutput("lu.first_b_flush", 16'(b_id_ex_flush), 16'd1);
        endCycle();
        clearInputs();
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput($sformatf("lu.tail%0d_a_flush", k), 16'(a_id_ex_flush), 16'(k < 2));
            checkOutput($sformatf("lu.tail%0d_b_flush", k), 16'(b_id_ex_flush), 16'd0);
            endCycle();
        end

        clearInputs();
        setLoadUse();
        id_uses_rs2 = 1'b0; id_uses_rs1 = 1'b1; id_rs1 = 5'd4;
        applyStimulus();
        checkOutput("lu.unused_src_stall", 16'(a_pc_stall), 16'd0);
        endCycle();
        setLoadUse();
        id_ex_rd = 5'd0; id_rs2 = 5'd0;
        applyStimulus();
        checkOutput("lu.x0_stall", 16'(a_pc_stall), 16'd0);
        endCycle();

        // Freeze landing on the second bubble holds the remaining bubble count.
        clearInputs();
        flushes = 0;
        setLoadUse();
        applyStimulus();
        flushes += int'(a_id_ex_flush);
        endCycle();
        clearInputs();
        dmem_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput($sformatf("frz%0d.flush", k), 16'(a_id_ex_flush), 16'd0);
            checkOutput($sformatf("frz%0d.pc_stall", k), 16'(a_pc_stall), 16'd1);
            flushes += int'(a_id_ex_flush);
            endCycle();
        end
        dmem_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput($sformatf("frz.after%0d_flush", k), 16'(a_id_ex_flush), 16'(k < 2));
            flushes += int'(a_id_ex_flush);
            endCycle();
        end
        checkOutput("frz.total_bubbles", 16'(flushes), 16'd3);
        applyStimulus();
        checkOutput("frz.a_timeout_set", 16'(a_mem_timeout), 16'd1);
        checkOutput("frz.b_timeout_clear", 16'(b_mem_timeout), 16'd0);
        endCycle();
        pulseReset();

        // Watchdog: three frozen cycles stay below the limit, four reach it.
        clearInputs();
        dmem_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput($sformatf("wd3.freeze%0d", k), 16'(a_pipe_freeze), 16'd1);
            endCycle();
        end
        dmem_ready = 1'b1;
        applyStimulus();
        checkOutput("wd3.released", 16'(a_pipe_freeze), 16'd0);
        checkOutput("wd3.no_timeout", 16'(a_mem_timeout), 16'd0);
        endCycle();
        dmem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            endCycle();
        end
        clearInputs();
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput($sformatf("wd4.sticky%0d", k), 16'(a_mem_timeout), 16'd1);
            endCycle();
        end
        pulseReset();
        applyStimulus();
        checkOutput("wd4.cleared_by_rst", 16'(a_mem_timeout), 16'd0);
        endCycle();

        // Reset landing on the second bubble aborts the sequence and history.
        clearInputs();
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd9;
        applyStimulus();
        endCycle();
        clearInputs();
        setLoadUse();
        applyStimulus();
        endCycle();
        clearInputs();
        rst = 1'b1;
        applyStimulus();
        checkOutput("rstbub.during_flush", 16'(a_id_ex_flush), 16'd0);
        endCycle();
        clearInputs();
        id_ex_rs1 = 5'd9;
        applyStimulus();
        checkOutput("rstbub.after_flush", 16'(a_id_ex_flush), 16'd0);
        checkOutput("rstbub.after_stall", 16'(a_pc_stall), 16'd0);
        checkOutput("rstbub.hist_dropped", 16'(a_fwd_rs1), 16'd0);
        endCycle();

        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 63) == 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_ex_rs1       = 5'($urandom_range(0, 3));
            id_ex_rs2       = 5'($urandom_range(0, 3));
            id_ex_rd        = 5'($urandom_range(0, 3));
            ex_mem_rd       = 5'($urandom_range(0, 3));
            mem_wb_rd       = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom);
            id_uses_rs2     = 1'($urandom);
            id_ex_memread   = 1'($urandom);
            ex_mem_regwrite = 1'($urandom);
            mem_wb_regwrite = 1'($urandom);
            dmem_req        = 1'($urandom);
            dmem_ready      = ($urandom_range(0, 3) == 0);
            applyStimulus();
            endCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
